// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM state encoding, parity modes
// and the 3-sample majority vote used for glitch-tolerant bit decisions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input pin; RESET_VAL sets the
// value both flops take during reset (idle level of the pin).
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with parity/framing/overrun flags and a one-entry
// output holding register. Define UART_RX_MAJORITY_EN for 3-sample bit voting.
// Handshake: rx_data/flags are stable while rx_valid=1; a transfer happens on
// any rising clk edge with rx_valid & rx_ready; rx_valid never depends on rx_ready.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 10417,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  UART_RX,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err,
    output logic                  rx_overrun,
    output logic [2:0]            rx_state
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] FULL_TERM = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_TERM = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    uart_state_e           state;
    logic [TW-1:0]         timer;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bit;
    logic                  ferr_acc;
    logic                  rxs;
    logic                  rxs_prev;
    logic                  bit_val;
    logic                  tick;
    logic                  complete;
    logic                  par_calc;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (UART_RX),
        .q   (rxs)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], rxs};
    end

    assign bit_val = majority3(hist[1], hist[0], rxs);
`else
    assign bit_val = rxs;
`endif

    assign tick     = (timer == ((state == ST_START) ? HALF_TERM : FULL_TERM));
    assign complete = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);
    assign rx_state = state;

    always_comb begin
        par_calc = 1'b0;
        if (PARITY_MODE == PARITY_EVEN)
            par_calc = ^shift ^ par_bit;
        else if (PARITY_MODE == PARITY_ODD)
            par_calc = ~(^shift ^ par_bit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
            rxs_prev <= 1'b1;
        end else begin
            rxs_prev <= rxs;
            if (state == ST_IDLE) begin
                timer    <= '0;
                bit_cnt  <= '0;
                ferr_acc <= 1'b0;
                // Only a 1->0 transition starts a frame, so a held-low break stays idle.
                if (rxs_prev && !rxs)
                    state <= ST_START;
            end else begin
                timer <= tick ? '0 : timer + TW'(1);
                if (tick) begin
                    case (state)
                        ST_START: begin
                            state   <= bit_val ? ST_IDLE : ST_DATA;
                            bit_cnt <= '0;
                        end
                        ST_DATA: begin
                            shift <= {bit_val, shift[DATA_WIDTH-1:1]};
                            if (bit_cnt == LAST_DATA) begin
                                bit_cnt <= '0;
                                state   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        ST_PARITY: begin
                            par_bit <= bit_val;
                            state   <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (!bit_val)
                                ferr_acc <= 1'b1;
                            if (bit_cnt == LAST_STOP)
                                state <= ST_IDLE;
                            else
                                bit_cnt <= bit_cnt + CW'(1);
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= complete && rx_valid && !rx_ready;
            if (complete && (!rx_valid || rx_ready)) begin
                rx_data       <= shift;
                rx_valid      <= 1'b1;
                rx_parity_err <= par_calc;
                rx_frame_err  <= ferr_acc | ~bit_val;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: an 8N1 instance and an 8E2 instance,
// hand sequences for timing/handshake corners, a vector table and random frames.
module tb_uart_rx_frame;

    localparam int C = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic tx_bit = 1'b1;
    logic sel    = 1'b0;
    logic glitch = 1'b0;
    logic ready0 = 1'b1;
    logic ready1 = 1'b1;
    logic line0, line1;

    assign line0 = sel ? 1'b1 : (tx_bit ^ glitch);
    assign line1 = sel ? (tx_bit ^ glitch) : 1'b1;

    logic [7:0] d0, d1;
    logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;
    logic [2:0] st0, st1;

    uart_rx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .UART_RX(line0), .rx_data(d0), .rx_valid(v0), .rx_ready(ready0),
        .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_overrun(ov0), .rx_state(st0));

    uart_rx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .PARITY_MODE(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .UART_RX(line1), .rx_data(d1), .rx_valid(v1), .rx_ready(ready1),
        .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_overrun(ov1), .rx_state(st1));

    int checks = 0;
    int errors = 0;
    int ov_cnt0 = 0;
    int rx_cnt0 = 0;
    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [1:0] stops;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bits go out LSB first: start, data, optional parity, stop bits (stops[0] first).
    task automatic send_frame(input logic [7:0] data, input int has_par, input logic par,
                              input logic [1:0] stops, input int nstop, input logic end_level);
        logic [15:0] bits;
        int n;
        bits = '0;
        bits[8:1] = data;
        n = 9;
        if (has_par != 0) begin
            bits[n] = par;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[n] = stops[i];
            n++;
        end
        for (int i = 0; i < n; i++) begin
            tx_bit = bits[i];
            wait_cyc(C);
        end
        tx_bit = end_level;
    endtask

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (v0 && ready0) begin
                rx_cnt0++;
                if (exp_q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut0_unexpected: got frame %0h expected none", d0);
                end else begin
                    e = exp_q0.pop_front();
                    check("dut0_frame", 32'({pe0, fe0, d0}), 32'(e));
                end
            end
            if (v1 && ready1) begin
                if (exp_q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut1_unexpected: got frame %0h expected none", d1);
                end else begin
                    e = exp_q1.pop_front();
                    check("dut1_frame", 32'({pe1, fe1, d1}), 32'(e));
                end
            end
            if (ov0) ov_cnt0++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int lat;
        int any_v;
        int saw_start;
        int base;
        logic [7:0] rd;
        logic rpar;
        logic [1:0] rst_bits;
        logic rstop;

        tbl[0] = '{8'h07, 1'b0, 2'b11, 1'b1, 1'b0};
        tbl[1] = '{8'h07, 1'b1, 2'b11, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 2'b11, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[5] = '{8'h3C, 1'b1, 2'b01, 1'b1, 1'b1};

        rst = 1'b1;
        wait_cyc(3);
        check("rst_valid", 32'(v0), 0);
        check("rst_data", 32'(d0), 0);
        check("rst_flags", 32'({pe0, fe0, ov0}), 0);
        check("rst_state", 32'(st0), 0);
        rst = 1'b0;
        wait_cyc(3);

        // 0xA5 8N1: rx_valid appears 155 edges after the start bit is driven
        sel = 1'b0;
        ready0 = 1'b1;
        exp_q0.push_back({2'b00, 8'hA5});
        lat = 0;
        fork
            send_frame(8'hA5, 0, 1'b0, 2'b11, 1, 1'b1);
            begin
                while (!v0 && lat < 300) begin
                    wait_cyc(1);
                    lat++;
                end
                check("a5_latency", 32'(lat), 155);
                check("a5_data", 32'(d0), 32'h A5);
                wait_cyc(1);
                check("a5_one_cycle", 32'(v0), 0);
            end
        join
        wait_cyc(10);

        // 6-cycle glitch is a false start
        tx_bit = 1'b0;
        wait_cyc(6);
        tx_bit = 1'b1;
        any_v = 0;
        saw_start = 0;
        for (int i = 0; i < 30; i++) begin
            wait_cyc(1);
            if (v0) any_v = 1;
            if (st0 == 3'd1) saw_start = 1;
        end
        check("glitch_saw_start", 32'(saw_start), 1);
        check("glitch_no_valid", 32'(any_v), 0);
        check("glitch_idle", 32'(st0), 0);
        exp_q0.push_back({2'b00, 8'h3C});
        send_frame(8'h3C, 0, 1'b0, 2'b11, 1, 1'b1);
        wait_cyc(10);

        // Vector table on the even-parity, 2-stop instance
        sel = 1'b1;
        ready1 = 1'b0;
        wait_cyc(4);
        for (int i = 0; i < 6; i++) begin
            exp_q1.push_back({tbl[i].exp_pe, tbl[i].exp_fe, tbl[i].data});
            send_frame(tbl[i].data, 1, tbl[i].par, tbl[i].stops, 2, 1'b1);
            check("tbl_valid", 32'(v1), 1);
            check("tbl_data", 32'(d1), 32'(tbl[i].data));
            check("tbl_perr", 32'(pe1), 32'(tbl[i].exp_pe));
            check("tbl_ferr", 32'(fe1), 32'(tbl[i].exp_fe));
            ready1 = 1'b1;
            wait_cyc(1);
            ready1 = 1'b0;
            wait_cyc(3);
            check("tbl_drained", 32'(v1), 0);
        end
        ready1 = 1'b1;
        sel = 1'b0;
        wait_cyc(4);

        // Break: stop bit low, line held low, only one frame
        base = rx_cnt0;
        exp_q0.push_back({2'b01, 8'h55});
        send_frame(8'h55, 0, 1'b0, 2'b00, 1, 1'b0);
        wait_cyc(100);
        check("break_one_frame", 32'(rx_cnt0 - base), 1);
        tx_bit = 1'b1;
        wait_cyc(20);
        exp_q0.push_back({2'b00, 8'h12});
        send_frame(8'h12, 0, 1'b0, 2'b11, 1, 1'b1);
        wait_cyc(10);
        check("break_recovered", 32'(rx_cnt0 - base), 2);

        // Overrun and completion coinciding with acceptance
        ready0 = 1'b0;
        send_frame(8'h11, 0, 1'b0, 2'b11, 1, 1'b1);
        wait_cyc(5);
        check("ovr_held_data", 32'(d0), 32'h11);
        base = ov_cnt0;
        send_frame(8'h22, 0, 1'b0, 2'b11, 1, 1'b1);
        wait_cyc(5);
        check("ovr_keep_data", 32'(d0), 32'h11);
        check("ovr_keep_valid", 32'(v0), 1);
        check("ovr_pulse_count", 32'(ov_cnt0 - base), 1);
        exp_q0.push_back({2'b00, 8'h11});
        fork
            send_frame(8'h44, 0, 1'b0, 2'b11, 1, 1'b1);
            begin
                wait_cyc(154);
                ready0 = 1'b1;
                wait_cyc(1);
                ready0 = 1'b0;
            end
        join
        check("coinc_valid", 32'(v0), 1);
        check("coinc_data", 32'(d0), 32'h44);
        check("coinc_no_ovr", 32'(ov_cnt0 - base), 1);
        exp_q0.push_back({2'b00, 8'h44});
        ready0 = 1'b1;
        wait_cyc(2);
        check("coinc_drained", 32'(v0), 0);

        // Reset mid-frame with a held frame present
        ready0 = 1'b0;
        send_frame(8'h5A, 0, 1'b0, 2'b11, 1, 1'b1);
        wait_cyc(3);
        check("pre_rst_valid", 32'(v0), 1);
        fork
            send_frame(8'hFF, 0, 1'b0, 2'b11, 1, 1'b1);
            begin
                wait_cyc(3 * C + 5);
                rst = 1'b1;
                #1;
                check("midrst_outputs", 32'({v0, d0, pe0, fe0, ov0}), 0);
                check("midrst_state", 32'(st0), 0);
                wait_cyc(2);
                rst = 1'b0;
            end
        join
        wait_cyc(20);
        check("midrst_no_frame", 32'(v0), 0);
        ready0 = 1'b1;
        wait_cyc(5);

        // One-cycle inverted glitch on the decision cycle of data bit 1
`ifdef UART_RX_MAJORITY_EN
        exp_q0.push_back({2'b00, 8'h0F});
`else
        exp_q0.push_back({2'b00, 8'h0D});
`endif
        fork
            send_frame(8'h0F, 0, 1'b0, 2'b11, 1, 1'b1);
            begin
                wait_cyc(C / 2 + 2 * C);
                glitch = 1'b1;
                wait_cyc(1);
                glitch = 1'b0;
            end
        join
        wait_cyc(10);

        // Random frames against the rule-based model
        for (int i = 0; i < 24; i++) begin
            rd = 8'($urandom_range(0, 255));
            sel = 1'($urandom_range(0, 1));
            wait_cyc($urandom_range(1, 20));
            if (sel) begin
                rpar = 1'($urandom_range(0, 1));
                rst_bits = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
                exp_q1.push_back({1'(($countones(rd) + int'(rpar)) % 2), 1'(rst_bits != 2'b11), rd});
                send_frame(rd, 1, rpar, rst_bits, 2, 1'b1);
            end else begin
                rstop = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
                exp_q0.push_back({1'b0, ~rstop, rd});
                send_frame(rd, 0, 1'b0, {1'b1, rstop}, 1, 1'b1);
            end
        end
        wait_cyc(20);
        check("q0_empty", 32'(exp_q0.size()), 0);
        check("q1_empty", 32'(exp_q1.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
